// File: rtl/tree_adder_pkg.sv
// Shared types and elaboration helpers for the configurable-precision tree adder.
package tree_adder_pkg;

   typedef enum logic [1:0] {
      FULL    = 2'd0,
      HALF    = 2'd1,
      QUARTER = 2'd2,
      RSVD    = 2'd3
   } precision_mode_e;

   // Number of pairwise adder levels needed to reduce n words to one.
   function automatic int tree_levels(input int n);
      int lv;
      lv = 0;
      while ((32'sd1 <<< lv) < n) begin
         lv = lv + 1;
      end
      return lv;
   endfunction

endpackage

// File: rtl/pipelined_config_tree_adder_if.sv
// Operand/result bus of the tree adder: beat stream in, group sums out.
interface pipelined_config_tree_adder_if #(
   parameter int P             = 16,
   parameter int INPUTS_AMOUNT = 8,
   parameter int OUT_W         = 32
);
   logic signed [P-1:0]     inputs [INPUTS_AMOUNT];
   logic [1:0]              precision_mode;
   logic                    in_last;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [OUT_W-1:0] out;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output inputs, precision_mode, in_last, in_valid, out_ready,
      input  in_ready, out, out_valid
   );

   modport slave (
      input  inputs, precision_mode, in_last, in_valid, out_ready,
      output in_ready, out, out_valid
   );
endinterface

// File: rtl/precision_lane_splitter.sv
// Splits one operand word into 1, 2 or 4 signed lanes and returns their sign-extended sum.
module precision_lane_splitter
   import tree_adder_pkg::*;
#(
   parameter int P = 16,
   parameter int W = P + 2
) (
   input  logic signed [P-1:0] word,
   input  precision_mode_e     mode,
   output logic signed [W-1:0] lane_sum
);
   localparam int H = P / 2;
   localparam int Q = P / 4;

   logic signed [H-1:0] hi_s;
   logic signed [H-1:0] lo_s;
   logic signed [Q-1:0] q_s [4];

   assign hi_s = word[P-1:H];
   assign lo_s = word[H-1:0];

   for (genvar k = 0; k < 4; k++) begin : g_q
      assign q_s[k] = word[k*Q +: Q];
   end

   // Mode-dependent lane reduction; the reserved encoding falls back to full width.
   always_comb begin
      lane_sum = W'(word);
      case (mode)
         HALF:       lane_sum = W'(hi_s) + W'(lo_s);
         QUARTER:    lane_sum = W'(q_s[0]) + W'(q_s[1]) + W'(q_s[2]) + W'(q_s[3]);
         FULL, RSVD: lane_sum = W'(word);
         default:    lane_sum = W'(word);
      endcase
   end

endmodule

// File: rtl/pipelined_config_tree_adder.sv
// Pipelined adder tree with per-beat precision, group accumulator and a global output stall.
module pipelined_config_tree_adder
   import tree_adder_pkg::*;
#(
   parameter int P             = 16,
   parameter int INPUTS_AMOUNT = 8,
   parameter int OUT_W         = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic signed [P-1:0]     inputs [INPUTS_AMOUNT],
   input  logic [1:0]              precision_mode,
   input  logic                    in_last,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [OUT_W-1:0] out,
   output logic                    out_valid,
   input  logic                    out_ready
);
   localparam int LEVELS = tree_levels(INPUTS_AMOUNT);
   localparam int W0     = P + 2;

   logic                    stall_s;
   precision_mode_e         mode_s;
   logic signed [W0-1:0]    split_s [INPUTS_AMOUNT];
   logic signed [OUT_W-1:0] tree_sum_s;
   logic signed [OUT_W-1:0] acc_r;
   logic signed [OUT_W-1:0] out_r;
   logic                    out_valid_r;

   assign mode_s   = precision_mode_e'(precision_mode);
   assign stall_s  = out_valid_r && !out_ready;
   assign in_ready = !stall_s;

   for (genvar g = 0; g < INPUTS_AMOUNT; g++) begin : g_split
      precision_lane_splitter #(.P(P), .W(W0)) u_split (
         .word     (inputs[g]),
         .mode     (mode_s),
         .lane_sum (split_s[g])
      );
   end

   // Level 0 registers the split words; each later level halves the node count and widens by one bit.
   for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
      localparam int WO = W0 + lv;
      localparam int NO = INPUTS_AMOUNT >> lv;

      logic signed [WO-1:0] node_r [NO];
      logic                 vld_r;
      logic                 last_r;

      if (lv == 0) begin : g_in
         // Capture the accepted beat; a bubble still advances as an invalid slot.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               vld_r  <= 1'b0;
               last_r <= 1'b0;
               for (int i = 0; i < NO; i++) node_r[i] <= '0;
            end else if (!stall_s) begin
               vld_r  <= in_valid;
               last_r <= in_last;
               for (int i = 0; i < NO; i++) node_r[i] <= split_s[i];
            end
         end
      end else begin : g_add
         // Pairwise reduction of the previous level.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               vld_r  <= 1'b0;
               last_r <= 1'b0;
               for (int i = 0; i < NO; i++) node_r[i] <= '0;
            end else if (!stall_s) begin
               vld_r  <= g_lvl[lv-1].vld_r;
               last_r <= g_lvl[lv-1].last_r;
               for (int i = 0; i < NO; i++) begin
                  node_r[i] <= WO'(g_lvl[lv-1].node_r[2*i]) + WO'(g_lvl[lv-1].node_r[2*i+1]);
               end
            end
         end
      end
   end

   assign tree_sum_s = OUT_W'(g_lvl[LEVELS].node_r[0]);

   // Group accumulator and output register; a closing beat publishes acc+sum and restarts the group.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_r       <= '0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
      end else if (!stall_s) begin
         if (g_lvl[LEVELS].vld_r) begin
            if (g_lvl[LEVELS].last_r) begin
               out_r       <= acc_r + tree_sum_s;
               out_valid_r <= 1'b1;
               acc_r       <= '0;
            end else begin
               acc_r       <= acc_r + tree_sum_s;
               out_valid_r <= 1'b0;
            end
         end else begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign out       = out_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_pipelined_config_tree_adder.sv
// Directed and random checks of pipelined_config_tree_adder against a lane-arithmetic scoreboard.
module tb_pipelined_config_tree_adder;
   localparam int P     = 16;
   localparam int N     = 8;
   localparam int OUT_W = 32;

   logic clk;
   logic rst_n;

   pipelined_config_tree_adder_if #(.P(P), .INPUTS_AMOUNT(N), .OUT_W(OUT_W)) bus ();

   pipelined_config_tree_adder #(.P(P), .INPUTS_AMOUNT(N), .OUT_W(OUT_W)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .inputs         (bus.inputs),
      .precision_mode (bus.precision_mode),
      .in_last        (bus.in_last),
      .in_valid       (bus.in_valid),
      .in_ready       (bus.in_ready),
      .out            (bus.out),
      .out_valid      (bus.out_valid),
      .out_ready      (bus.out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   int edge_cnt;
   int out_cnt;
   int acc_cnt;
   logic acc_flag;
   logic last_in_ready;
   logic stalled_prev;
   logic signed [OUT_W-1:0] prev_out;
   logic signed [OUT_W-1:0] last_out;
   logic signed [OUT_W-1:0] exp_q [$];
   longint acc_model;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Sum of all lanes of the current beat, lanes read as two's-complement numbers.
   function automatic longint beat_sum(input logic [1:0] m);
      int lw;
      longint s;
      longint v;
      longint unsigned w;
      longint unsigned v_u;
      lw = (m == 2'd1) ? P / 2 : (m == 2'd2) ? P / 4 : P;
      s = 0;
      for (int i = 0; i < N; i++) begin
         w = {48'd0, bus.inputs[i]};
         for (int k = 0; k < P / lw; k++) begin
            v_u = (w >> (k * lw)) & ((64'd1 << lw) - 64'd1);
            v = longint'(v_u);
            if (v >= (longint'(1) << (lw - 1))) v = v - (longint'(1) << lw);
            s += v;
         end
      end
      return s;
   endfunction

   task automatic tick();
      logic hs;
      logic signed [OUT_W-1:0] e;
      @(negedge clk);
      acc_flag = bus.in_valid && bus.in_ready;
      hs = bus.out_valid && bus.out_ready;
      last_in_ready = bus.in_ready;
      chk("ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (stalled_prev) begin
         chk("stall_out", 64'(bus.out), 64'(prev_out));
         chk("stall_valid", 64'(bus.out_valid), 64'(1));
      end
      if (hs) begin
         if (exp_q.size() == 0) begin
            chk("extra_out", 64'(bus.out_valid), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("sum", 64'(bus.out), 64'(e));
         end
         last_out = bus.out;
         out_cnt++;
      end
      if (acc_flag) begin
         acc_model += beat_sum(bus.precision_mode);
         acc_cnt++;
         if (bus.in_last) begin
            e = acc_model[OUT_W-1:0];
            exp_q.push_back(e);
            acc_model = 0;
         end
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_out = bus.out;
      @(posedge clk);
      edge_cnt++;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_out", 64'(bus.out), 64'(0));
      exp_q.delete();
      acc_model = 0;
      stalled_prev = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [1:0] m, input logic l);
      bus.precision_mode = m;
      bus.in_last = l;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (acc_flag) break;
      end
      chk("send_accept", 64'(acc_flag), 64'(1));
      bus.in_valid = 1'b0;
   endtask

   task automatic flush();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      chk("drain", 64'(exp_q.size()), 64'(0));
      tick();
      tick();
      chk("idle_valid", 64'(bus.out_valid), 64'(0));
   endtask

   task automatic words_ramp();
      for (int i = 0; i < N; i++) bus.inputs[i] = 16'(i + 1);
   endtask

   task automatic words_rand();
      for (int i = 0; i < N; i++) bus.inputs[i] = 16'($urandom);
   endtask

   initial begin
      int ae;
      int oc;
      int ac;
      total = 0; bad = 0; edge_cnt = 0; out_cnt = 0; acc_cnt = 0;
      acc_flag = 1'b0; last_in_ready = 1'b0; stalled_prev = 1'b0;
      prev_out = '0; last_out = '0; acc_model = 0;
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.precision_mode = 2'd0; bus.out_ready = 1'b1;
      for (int i = 0; i < N; i++) bus.inputs[i] = 16'd0;
      rst_n = 1'b1;
      #1;
      do_reset();

      // Full mode 1..8, latency from acceptance edge to out_valid
      words_ramp();
      bus.precision_mode = 2'd0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
      tick();
      ae = edge_cnt;
      chk("accept1", 64'(acc_flag), 64'(1));
      bus.in_valid = 1'b0;
      for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) tick();
      chk("latency", 64'(edge_cnt - ae), 64'(4));
      flush();
      chk("full36", 64'(last_out), 64'(36));

      // Half mode {2j+1, 2j+2} and negated
      for (int j = 0; j < N; j++) bus.inputs[j] = {8'(2 * j + 1), 8'(2 * j + 2)};
      send(2'd1, 1'b1);
      flush();
      chk("half136", 64'(last_out), 64'(136));
      for (int j = 0; j < N; j++) bus.inputs[j] = {8'(-(2 * j + 1)), 8'(-(2 * j + 2))};
      send(2'd1, 1'b1);
      flush();
      chk("half_neg136", 64'(last_out), -64'sd136);

      // Quarter mode nibbles
      for (int j = 0; j < N; j++) bus.inputs[j] = 16'h1234;
      send(2'd2, 1'b1);
      flush();
      chk("quarter80", 64'(last_out), 64'(80));
      for (int j = 0; j < N; j++) bus.inputs[j] = 16'h8888;
      send(2'd2, 1'b1);
      flush();
      chk("quarter_neg256", 64'(last_out), -64'sd256);

      // Three-beat group
      oc = out_cnt;
      words_ramp();
      send(2'd0, 1'b0);
      send(2'd0, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      chk("acc_no_out", 64'(out_cnt - oc), 64'(0));
      send(2'd0, 1'b1);
      flush();
      chk("acc108", 64'(last_out), 64'(108));
      chk("acc_count", 64'(out_cnt - oc), 64'(1));

      // Backpressure while streaming single-beat groups
      oc = out_cnt; ac = acc_cnt;
      bus.precision_mode = 2'd0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
      words_rand();
      for (int t = 0; t < 20; t++) begin
         bus.out_ready = !(t >= 6 && t < 11);
         tick();
         if (t == 9) chk("bp_in_ready", 64'(last_in_ready), 64'(0));
         if (acc_flag) words_rand();
      end
      flush();
      chk("bp_count", 64'(out_cnt - oc), 64'(acc_cnt - ac));

      // Random mixed-mode stream
      ac = acc_cnt;
      for (int t = 0; t < 3000 && (acc_cnt - ac) < 200; t++) begin
         bus.in_valid = ($urandom % 4) != 0;
         bus.precision_mode = 2'($urandom);
         bus.in_last = ($urandom % 3) == 0;
         bus.out_ready = ($urandom % 4) != 0;
         words_rand();
         tick();
      end
      chk("rand_beats", 64'(acc_cnt - ac), 64'(200));
      bus.out_ready = 1'b1;
      words_rand();
      send(2'($urandom), 1'b1);
      flush();

      // Reset with an open group in flight
      words_ramp();
      send(2'd0, 1'b0);
      send(2'd0, 1'b0);
      do_reset();
      oc = out_cnt;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("post_rst_valid", 64'(bus.out_valid), 64'(0));
      end
      send(2'd0, 1'b1);
      flush();
      chk("rst36", 64'(last_out), 64'(36));
      chk("rst_count", 64'(out_cnt - oc), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_config_tree_adder.md
PIPELINED_CONFIG_TREE_ADDER -- requirements
Module: pipelined_config_tree_adder

Interface
REQ-001 SHALL have parameter P, default 16: input word width in bits; multiple of 4, >=8.
REQ-002 SHALL have parameter INPUTS_AMOUNT, default 8: words per beat; power of 2, >=2.
REQ-003 SHALL have parameter OUT_W, default 32: result width; >= P+log2(INPUTS_AMOUNT)+2.
REQ-004 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port inputs  input  INPUTS_AMOUNT x P signed  operand words.
REQ-007 SHALL have port precision_mode  input  2  0=full, 1=half, 2=quarter, 3=reserved.
REQ-008 SHALL have port in_last  input  1  beat closes the accumulation group.
REQ-009 SHALL have port in_valid  input  1  beat offered.
REQ-010 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-011 SHALL have port out  output  OUT_W signed  group sum.
REQ-012 SHALL have port out_valid  output  1  out holds a group sum.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out.

Function
REQ-014 Full mode SHALL treat each word as one P-bit signed value; half mode as two P/2-bit signed values {hi,lo}; quarter mode as four P/4-bit signed values; all sign-extended before addition.
REQ-015 Mode 3 SHALL behave exactly as full mode.
REQ-016 precision_mode and in_last SHALL be captured per accepted beat and travel with that beat; mixed modes between consecutive beats SHALL be legal.
REQ-017 Tree SHALL have log2(INPUTS_AMOUNT) adder levels, each followed by a pipeline register; level widths grow by 1 bit per level.
REQ-018 Accumulator SHALL add each beat's tree sum to acc; on a last beat, acc+sum SHALL load into out, out_valid SHALL assert, and acc SHALL clear to 0 in the same cycle.
REQ-019 Latency from accepting a last beat to out_valid SHALL be log2(INPUTS_AMOUNT)+1 cycles with no stall; throughput one beat per cycle.
REQ-020 Arithmetic SHALL wrap modulo 2^OUT_W; no saturation, no overflow flag.
REQ-021 Pipeline SHALL stall globally (all registers hold) when out_valid && !out_ready; in_ready SHALL equal !(out_valid && !out_ready).
REQ-022 out and out_valid SHALL stay stable while stalled; out_valid SHALL drop the cycle after handshake unless a new last beat completes in that cycle.
REQ-023 Pipeline bubbles (in_valid=0) SHALL propagate as invalid slots and SHALL NOT modify acc.
REQ-024 A group of one beat (in_last=1 on every beat) SHALL yield one output per beat (pure adder).

Reset
REQ-025 On rst_ni low, all stage valid bits, acc, out and out_valid SHALL clear to 0 immediately; in_ready SHALL read 1.
REQ-026 Reset mid-group or mid-pipeline SHALL discard all partial sums; no output SHALL be produced for in-flight beats.

Structure
REQ-027 Package tree_adder_pkg SHALL hold precision_mode_e (FULL, HALF, QUARTER, RSVD) and a function computing the level count from INPUTS_AMOUNT.
REQ-028 Per-word mode-dependent lane splitting and sign extension SHALL live in sub-module precision_lane_splitter (one instance per input word); tree levels, accumulator and handshake stay in the top module.

Verification
REQ-029 Full mode, inputs 1..8, in_last=1, out_ready=1 -> out=36, out_valid exactly 4 cycles after acceptance.
REQ-030 Half mode, word j = {2j+1, 2j+2} (j=0..7), in_last=1 -> out=136; same with all values negated -> -136.
REQ-031 Quarter mode, every word = nibbles {1,2,3,4} -> out=80; every word = nibbles {-8,-8,-8,-8} -> -256.
REQ-032 Accumulate: three full-mode beats of inputs 1..8, in_last only on third -> single output 108; no out_valid for beats 1-2.
REQ-033 Backpressure: out_ready=0 for 5 cycles while streaming single-beat groups -> in_ready=0 during stall, out stable, no result lost or duplicated; random 200-beat mixed-mode stream matches scoreboard.
REQ-034 Reset pulse with two beats in flight and an open group -> out_valid=0, next group 1..8 yields exactly 36.
